ff_bank: RTL and testbench

- Parametrised multi-channel flip-flop bank and successor to the single-channel SR flip-flop.
- Each of N_CH channels is independently configured at run time as a D, T, SR or JK flip-flop.
- Provides a configurable policy for the SR illegal input, sticky per-channel illegal-input flags, and saturating per-channel output-change counters.
- Used as a generic control/status state element and as a debug-observable latch array.

---
 rtl/ff_bank.sv | 101 ++++++++++
 tb/tb_ff_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// Multi-channel flip-flop bank: each channel runs as D, T, SR or JK at run time,
// with sticky SR-illegal flags and saturating per-channel Q-change counters.
module ff_bank #(
    parameter int unsigned     N_CH      = 4,
    parameter int unsigned     CNT_W     = 8,
    parameter int unsigned     SR_POLICY = 0,
    parameter logic [N_CH-1:0] INIT_Q    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH-1:0]         din_a,
    input  logic [N_CH-1:0]         din_b,
    input  logic                    clr_err,
    output logic [N_CH-1:0]         dout_q,
    output logic [N_CH-1:0]         dout_qb,
    output logic [N_CH-1:0]         err_illegal,
    output logic [N_CH*CNT_W-1:0]   chg_cnt
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_SR = 2'b10,
        MODE_JK = 2'b11
    } ch_mode_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_mode_t         ch_mode;
        logic             a;
        logic             b;
        logic             q_r;
        logic             q_nxt;
        logic             illegal;
        logic             err_r;
        logic [CNT_W-1:0] cnt_r;

        assign ch_mode = ch_mode_t'(mode[2*i +: 2]);
        assign a       = din_a[i];
        assign b       = din_b[i];

        always_comb begin
            q_nxt   = q_r;
            illegal = 1'b0;
            unique case (ch_mode)
                MODE_D:  q_nxt = a;
                MODE_T:  q_nxt = q_r ^ a;
                MODE_SR: begin
                    unique case ({a, b})
                        2'b00: q_nxt = q_r;
                        2'b10: q_nxt = 1'b1;
                        2'b01: q_nxt = 1'b0;
                        2'b11: begin
                            illegal = 1'b1;
                            case (SR_POLICY)
                                1:       q_nxt = 1'b1;
                                2:       q_nxt = 1'b0;
                                default: q_nxt = q_r;
                            endcase
                        end
                    endcase
                end
                MODE_JK: begin
                    unique case ({a, b})
                        2'b00: q_nxt = q_r;
                        2'b10: q_nxt = 1'b1;
                        2'b01: q_nxt = 1'b0;
                        2'b11: q_nxt = ~q_r;
                    endcase
                end
            endcase
        end

        // A new illegal input on the same edge as clr_err keeps the flag set.
        always_ff @(posedge clk) begin
            if (rst) begin
                q_r   <= INIT_Q[i];
                err_r <= 1'b0;
                cnt_r <= '0;
            end else begin
                if (en) begin
                    q_r <= q_nxt;
                    if ((q_nxt != q_r) && (cnt_r != '1))
                        cnt_r <= cnt_r + CNT_W'(1);
                end
                if (en && illegal)
                    err_r <= 1'b1;
                else if (clr_err)
                    err_r <= 1'b0;
            end
        end

        assign dout_q[i]                   = q_r;
        assign err_illegal[i]              = err_r;
        assign chg_cnt[CNT_W*i +: CNT_W]   = cnt_r;
    end

    assign dout_qb = ~dout_q;

endmodule

// File: tb/tb_ff_bank.sv
// Scoreboard bench for ff_bank: three instances (SR_POLICY 0/1/2, 8- and 3-bit counters)
// share stimulus; a behavioural model pushes expectations that each test pops and checks.
module tb_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] mode = '0;
    logic [3:0] din_a = '0;
    logic [3:0] din_b = '0;
    logic       clr_err = 1'b0;

    logic [3:0]  q_p0, q_p1, q_p2, qb_p0, qb_p1, qb_p2, err_p0, err_p1, err_p2;
    logic [31:0] cnt_p0;
    logic [11:0] cnt_p1, cnt_p2;

    logic [11:0] obs_q, obs_qb, obs_err;
    logic [55:0] obs_cnt;
    assign obs_q   = {q_p2, q_p1, q_p0};
    assign obs_qb  = {qb_p2, qb_p1, qb_p0};
    assign obs_err = {err_p2, err_p1, err_p0};
    assign obs_cnt = {cnt_p2, cnt_p1, cnt_p0};

    localparam logic [3:0] INIT = 4'b1010;

    ff_bank #(.N_CH(4), .CNT_W(8), .SR_POLICY(0), .INIT_Q(INIT)) u_p0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din_a(din_a), .din_b(din_b),
        .clr_err(clr_err), .dout_q(q_p0), .dout_qb(qb_p0), .err_illegal(err_p0), .chg_cnt(cnt_p0));
    ff_bank #(.N_CH(4), .CNT_W(3), .SR_POLICY(1), .INIT_Q(INIT)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din_a(din_a), .din_b(din_b),
        .clr_err(clr_err), .dout_q(q_p1), .dout_qb(qb_p1), .err_illegal(err_p1), .chg_cnt(cnt_p1));
    ff_bank #(.N_CH(4), .CNT_W(3), .SR_POLICY(2), .INIT_Q(INIT)) u_p2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din_a(din_a), .din_b(din_b),
        .clr_err(clr_err), .dout_q(q_p2), .dout_qb(qb_p2), .err_illegal(err_p2), .chg_cnt(cnt_p2));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] q;
        logic [11:0] err;
        logic [55:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0] mq  [3];
    logic [3:0] merr[3];
    int         mc  [3][4];

    // Drives one cycle of stimulus, advances the model and queues the expectation.
    task automatic apply(input logic r, input logic e, input logic [7:0] md,
                         input logic [3:0] a, input logic [3:0] b, input logic c);
        exp_t x;
        logic [1:0] m;
        logic nq;
        int cmax;
        rst = r; en = e; mode = md; din_a = a; din_b = b; clr_err = c;
        for (int d = 0; d < 3; d++) begin
            cmax = (d == 0) ? 255 : 7;
            for (int i = 0; i < 4; i++) begin
                m = md[2*i +: 2];
                nq = mq[d][i];
                if (m == 2'b00) nq = a[i];
                else if (m == 2'b01) nq = a[i] ? ~mq[d][i] : mq[d][i];
                else if (a[i] && !b[i]) nq = 1'b1;
                else if (!a[i] && b[i]) nq = 1'b0;
                else if (a[i] && b[i]) begin
                    if (m == 2'b11) nq = ~mq[d][i];
                    else if (d == 1) nq = 1'b1;
                    else if (d == 2) nq = 1'b0;
                end
                if (r) begin
                    mq[d][i] = INIT[i]; merr[d][i] = 1'b0; mc[d][i] = 0;
                end else begin
                    if (e) begin
                        if (nq != mq[d][i] && mc[d][i] < cmax) mc[d][i]++;
                        mq[d][i] = nq;
                    end
                    if (e && m == 2'b10 && a[i] && b[i]) merr[d][i] = 1'b1;
                    else if (c) merr[d][i] = 1'b0;
                end
            end
        end
        x.q   = {mq[2], mq[1], mq[0]};
        x.err = {merr[2], merr[1], merr[0]};
        for (int i = 0; i < 4; i++) begin
            x.cnt[8*i +: 8]       = 8'(mc[0][i]);
            x.cnt[32 + 3*i +: 3]  = 3'(mc[1][i]);
            x.cnt[44 + 3*i +: 3]  = 3'(mc[2][i]);
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            apply(k < 2, 1'(k < 2 ? $urandom : 0), 8'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom));
            x = sb.pop_front();
            checks++; if (obs_q !== x.q) begin errors++; $display("FAIL reset q got %h exp %h", obs_q, x.q); end
            checks++; if (obs_qb !== ~x.q) begin errors++; $display("FAIL reset qb got %h exp %h", obs_qb, ~x.q); end
            checks++; if (obs_err !== x.err) begin errors++; $display("FAIL reset err got %h exp %h", obs_err, x.err); end
            checks++; if (obs_cnt !== x.cnt) begin errors++; $display("FAIL reset cnt got %h exp %h", obs_cnt, x.cnt); end
        end
        checks++; if (q_p0 !== 4'b1010 || qb_p0 !== 4'b0101) begin
            errors++; $display("FAIL reset_init q got %b qb %b exp 1010/0101", q_p0, qb_p0);
        end
    endtask

    task automatic test_mode_sweep();
        exp_t x;
        logic [3:0] a_t[4] = '{4'b0000, 4'b1111, 4'b0011, 4'b0011};
        logic [3:0] b_t[4] = '{4'b0000, 4'b1000, 4'b0000, 4'b0100};
        logic [3:0] q_t[4] = '{4'b0000, 4'b1111, 4'b1101, 4'b1011};
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b1, (k == 0) ? 8'h00 : 8'hE4, a_t[k], b_t[k], 1'b0);
            x = sb.pop_front();
            checks++; if (obs_q !== x.q) begin errors++; $display("FAIL sweep q got %h exp %h", obs_q, x.q); end
            checks++; if (obs_qb !== ~x.q) begin errors++; $display("FAIL sweep qb got %h exp %h", obs_qb, ~x.q); end
            checks++; if (obs_err !== x.err) begin errors++; $display("FAIL sweep err got %h exp %h", obs_err, x.err); end
            checks++; if (obs_cnt !== x.cnt) begin errors++; $display("FAIL sweep cnt got %h exp %h", obs_cnt, x.cnt); end
            checks++; if (q_p0 !== q_t[k]) begin errors++; $display("FAIL sweep_const q got %b exp %b", q_p0, q_t[k]); end
        end
        checks++; if (cnt_p0[15:8] !== 8'd4) begin errors++; $display("FAIL sweep_cnt1 got %0d exp 4", cnt_p0[15:8]); end
    endtask

    task automatic test_sr_illegal();
        exp_t x;
        logic [3:0] a_t[4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic [3:0] b_t[4] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000};
        logic       c_t[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] e_t[4] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000};
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b1, 8'h20, a_t[k], b_t[k], c_t[k]);
            x = sb.pop_front();
            checks++; if (obs_q !== x.q) begin errors++; $display("FAIL sr q got %h exp %h", obs_q, x.q); end
            checks++; if (obs_qb !== ~x.q) begin errors++; $display("FAIL sr qb got %h exp %h", obs_qb, ~x.q); end
            checks++; if (obs_err !== x.err) begin errors++; $display("FAIL sr err got %h exp %h", obs_err, x.err); end
            checks++; if (obs_cnt !== x.cnt) begin errors++; $display("FAIL sr cnt got %h exp %h", obs_cnt, x.cnt); end
            checks++; if (err_p1 !== e_t[k]) begin errors++; $display("FAIL sr_flag got %b exp %b", err_p1, e_t[k]); end
            if (k == 1) begin
                checks++;
                if ({q_p2[2], q_p1[2], q_p0[2]} !== 3'b011) begin
                    errors++; $display("FAIL sr_policy got %b exp 011", {q_p2[2], q_p1[2], q_p0[2]});
                end
            end
        end
    endtask

    task automatic test_enable_gating();
        exp_t x;
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b0, 8'h24, 4'b0110, 4'b0100, 1'b0);
            x = sb.pop_front();
            checks++; if (obs_q !== x.q) begin errors++; $display("FAIL gate q got %h exp %h", obs_q, x.q); end
            checks++; if (obs_err !== x.err) begin errors++; $display("FAIL gate err got %h exp %h", obs_err, x.err); end
            checks++; if (obs_cnt !== x.cnt) begin errors++; $display("FAIL gate cnt got %h exp %h", obs_cnt, x.cnt); end
        end
        checks++; if (obs_err !== 12'h000) begin errors++; $display("FAIL gate_flag got %h exp 000", obs_err); end
    endtask

    task automatic test_saturation();
        exp_t x;
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, 1'b1, 8'h01, 4'b0001, 4'b0000, 1'b0);
            x = sb.pop_front();
            checks++; if (obs_q !== x.q) begin errors++; $display("FAIL sat q got %h exp %h", obs_q, x.q); end
            checks++; if (obs_cnt !== x.cnt) begin errors++; $display("FAIL sat cnt got %h exp %h", obs_cnt, x.cnt); end
        end
        checks++; if (cnt_p1[2:0] !== 3'd7 || cnt_p2[2:0] !== 3'd7) begin
            errors++; $display("FAIL sat_const got %0d/%0d exp 7", cnt_p1[2:0], cnt_p2[2:0]);
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t x;
        for (int k = 0; k < 2; k++) begin
            apply(k == 1, 1'b1, 8'h21, 4'b0101, 4'b0100, 1'b0);
            x = sb.pop_front();
            checks++; if (obs_q !== x.q) begin errors++; $display("FAIL midrst q got %h exp %h", obs_q, x.q); end
            checks++; if (obs_err !== x.err) begin errors++; $display("FAIL midrst err got %h exp %h", obs_err, x.err); end
            checks++; if (obs_cnt !== x.cnt) begin errors++; $display("FAIL midrst cnt got %h exp %h", obs_cnt, x.cnt); end
        end
        checks++; if (obs_q !== 12'hAAA || obs_err !== 12'h000 || obs_cnt !== 56'h0) begin
            errors++; $display("FAIL midrst_const q %h err %h cnt %h exp aaa/000/0", obs_q, obs_err, obs_cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        for (int k = 0; k < 60; k++) begin
            apply($urandom_range(0, 15) == 0, 1'($urandom), 8'($urandom), 4'($urandom),
                  4'($urandom), $urandom_range(0, 7) == 0);
            x = sb.pop_front();
            checks++; if (obs_q !== x.q) begin errors++; $display("FAIL b2b q got %h exp %h", obs_q, x.q); end
            checks++; if (obs_qb !== ~x.q) begin errors++; $display("FAIL b2b qb got %h exp %h", obs_qb, ~x.q); end
            checks++; if (obs_err !== x.err) begin errors++; $display("FAIL b2b err got %h exp %h", obs_err, x.err); end
            checks++; if (obs_cnt !== x.cnt) begin errors++; $display("FAIL b2b cnt got %h exp %h", obs_cnt, x.cnt); end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            mq[d] = 4'bxxxx; merr[d] = 4'bxxxx;
            for (int i = 0; i < 4; i++) mc[d][i] = 0;
        end
        test_reset();
        test_mode_sweep();
        test_sr_illegal();
        test_enable_gating();
        test_saturation();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
